// File: rtl/videofifo_fetch.sv
// Frame fetcher and 16-word show-ahead prefetch FIFO feeding the video output.
// Restarts the frame from base_addr on every synchronized vsync falling edge.
module videofifo_fetch #(
  parameter int addr_bits   = 30,
  parameter int fifo_log2   = 4,
  parameter int frame_words = 38400
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [addr_bits-1:0] base_addr,
  input  logic                 vga_vsync,
  input  logic                 rd,
  output logic                 mem_req,
  output logic [addr_bits-1:0] mem_addr,
  input  logic                 mem_ack,
  input  logic [31:0]          mem_data,
  output logic [7:0]           red_byte,
  output logic [7:0]           green_byte,
  output logic [7:0]           blue_byte,
  output logic [7:0]           bright_byte,
  output logic [fifo_log2:0]   level,
  output logic                 underflow
);

  localparam int DEPTH = 2 ** fifo_log2;

  localparam logic [fifo_log2:0] FULL =
    {1'b1, {fifo_log2{1'b0}}};
  localparam logic [fifo_log2:0] L1 =
    {{fifo_log2{1'b0}}, 1'b1};
  localparam logic [fifo_log2-1:0] P1 =
    {{(fifo_log2-1){1'b0}}, 1'b1};
  localparam logic [addr_bits-1:0] A1 =
    {{(addr_bits-1){1'b0}}, 1'b1};
  localparam logic [15:0] FW = 16'(frame_words);

  typedef enum logic [1:0] {
    S_WAIT,
    S_FILL,
    S_REQ,
    S_ABORT
  } state_t;

  state_t               state;
  logic [2:0]           vs_q;
  logic [addr_bits-1:0] addr;
  logic [15:0]          wcnt;
  logic [fifo_log2-1:0] wptr;
  logic [fifo_log2-1:0] rptr;
  logic [fifo_log2-1:0] rptr_nx;
  logic [31:0]          head;
  logic [31:0]          mem [DEPTH];

  logic restart;
  logic push;
  logic pop;

  // vs_q[1] is the synchronized vsync, vs_q[2] its previous value
  assign restart = vs_q[2] & ~vs_q[1];

  assign push    = (state == S_REQ) && mem_ack && !restart;
  assign pop     = rd && (level != '0) && !restart;
  assign rptr_nx = rptr + P1;

  assign red_byte    = head[7:0];
  assign green_byte  = head[15:8];
  assign blue_byte   = head[23:16];
  assign bright_byte = head[31:24];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      vs_q <= 3'b111;
    end else begin
      vs_q <= {vs_q[1:0], vga_vsync};
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= mem_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= S_WAIT;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      addr      <= '0;
      wcnt      <= '0;
      wptr      <= '0;
      rptr      <= '0;
      level     <= '0;
      head      <= '0;
      underflow <= 1'b0;
    end else if (restart) begin
      wptr      <= '0;
      rptr      <= '0;
      level     <= '0;
      addr      <= base_addr;
      wcnt      <= '0;
      underflow <= 1'b0;
      // an in-flight request must still be acked before reissuing
      if ((state == S_REQ || state == S_ABORT) && !mem_ack) begin
        state <= S_ABORT;
      end else begin
        state   <= S_FILL;
        mem_req <= 1'b0;
      end
    end else begin
      unique case (state)
        S_WAIT: begin
          mem_req <= 1'b0;
        end
        S_FILL: begin
          if (wcnt == FW) begin
            state <= S_WAIT;
          end else if (level != FULL) begin
            mem_req  <= 1'b1;
            mem_addr <= addr;
            state    <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem_ack) begin
            addr    <= addr + A1;
            mem_req <= 1'b0;
            state   <= S_FILL;
            if (wcnt != FW) begin
              wcnt <= wcnt + 16'd1;
            end
          end
        end
        S_ABORT: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= S_FILL;
          end
        end
        default: begin
          state <= S_WAIT;
        end
      endcase

      if (rd && level == '0) begin
        underflow <= 1'b1;
      end

      if (push) begin
        wptr <= wptr + P1;
      end
      if (pop) begin
        rptr <= rptr_nx;
      end

      case ({push, pop})
        2'b10:   level <= level + L1;
        2'b01:   level <= level - L1;
        default: level <= level;
      endcase

      // head register always mirrors the entry at rptr
      if (pop) begin
        if (level > L1) begin
          head <= mem[rptr_nx];
        end else if (push) begin
          head <= mem_data;
        end
      end else if (push && level == '0) begin
        head <= mem_data;
      end
    end
  end

endmodule

// File: tb/tb_videofifo_fetch.sv
// Directed bench for videofifo_fetch with a small frame and an
// in-line memory responder returning data = address.
module tb_videofifo_fetch;

  logic        clk = 1'b0;
  logic        resetn;
  logic [29:0] base_addr;
  logic        vga_vsync;
  logic        rd;
  logic        mem_req;
  logic [29:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;
  logic [7:0]  red_byte;
  logic [7:0]  green_byte;
  logic [7:0]  blue_byte;
  logic [7:0]  bright_byte;
  logic [4:0]  level;
  logic        underflow;

  int nasserts = 0;
  int nfail    = 0;
  int ack_en   = 1;
  int ack_dly  = 1;
  int cnt      = 0;
  int facks    = 0;
  logic [29:0] frame_lo = 30'h3fff_ffff;

  videofifo_fetch #(
    .addr_bits  (30),
    .fifo_log2  (4),
    .frame_words(48)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .base_addr  (base_addr),
    .vga_vsync  (vga_vsync),
    .rd         (rd),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_data   (mem_data),
    .red_byte   (red_byte),
    .green_byte (green_byte),
    .blue_byte  (blue_byte),
    .bright_byte(bright_byte),
    .level      (level),
    .underflow  (underflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    if (ack_en != 0) begin
      mem_ack = 1'b0;
      if (mem_req) begin
        if (cnt >= ack_dly) begin
          mem_ack  = 1'b1;
          mem_data = {2'b00, mem_addr};
          cnt      = 0;
          if (mem_addr >= frame_lo) facks++;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    nasserts++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] headw();
    return {bright_byte, blue_byte, green_byte, red_byte};
  endfunction

  initial begin
    resetn    = 1'b0;
    base_addr = 30'h100;
    vga_vsync = 1'b1;
    rd        = 1'b0;
    mem_ack   = 1'b0;
    mem_data  = '0;
    step();
    step();
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_head", headw(), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_unf", 32'(underflow), 32'd0);
    resetn = 1'b1;
    step();
    step();

    // underflow before any frame
    rd = 1'b1;
    step();
    rd = 1'b0;
    step();
    check("unf_set", 32'(underflow), 32'd1);
    check("unf_head", headw(), 32'd0);
    check("unf_level", 32'(level), 32'd0);
    check("unf_noreq", 32'(mem_req), 32'd0);

    // vsync falling edge: flush at 3rd edge, request at 4th
    vga_vsync = 1'b0;
    step();
    step();
    step();
    check("vs_unf_clr", 32'(underflow), 32'd0);
    check("vs_req_lo", 32'(mem_req), 32'd0);
    step();
    check("vs_req_hi", 32'(mem_req), 32'd1);
    check("vs_addr", 32'(mem_addr), 32'h100);
    vga_vsync = 1'b1;

    for (int i = 0; i < 200 && level != 5'd16; i++) step();
    check("fill_level", 32'(level), 32'd16);
    for (int i = 0; i < 20; i++) step();
    check("full_noreq", 32'(mem_req), 32'd0);
    check("full_level", 32'(level), 32'd16);
    check("full_red", 32'(red_byte), 32'h00);
    check("full_green", 32'(green_byte), 32'h01);
    check("full_blue", 32'(blue_byte), 32'h00);
    check("full_bright", 32'(bright_byte), 32'h00);

    // single pop from full
    ack_dly = 10;
    rd = 1'b1;
    step();
    rd = 1'b0;
    check("pop_level", 32'(level), 32'd15);
    check("pop_head", headw(), 32'h101);

    // abort: restart while a slow request is outstanding
    for (int i = 0; i < 10 && !mem_req; i++) step();
    check("ab_req", 32'(mem_req), 32'd1);
    check("ab_addr0", 32'(mem_addr), 32'h110);
    base_addr = 30'h200;
    vga_vsync = 1'b0;
    step();
    step();
    step();
    check("ab_flush", 32'(level), 32'd0);
    check("ab_hold", 32'(mem_req), 32'd1);
    for (int i = 0; i < 20 && mem_req; i++) step();
    check("ab_acked", 32'(mem_req), 32'd0);
    check("ab_discard", 32'(level), 32'd0);
    step();
    check("ab_newreq", 32'(mem_req), 32'd1);
    check("ab_newaddr", 32'(mem_addr), 32'h200);
    vga_vsync = 1'b1;

    // simultaneous push and pop at level 5
    ack_dly = 1;
    for (int i = 0; i < 200 && !(level == 5'd5 && mem_ack); i++) step();
    check("pp_pre_lvl", 32'(level), 32'd5);
    check("pp_pre_ack", 32'(mem_ack), 32'd1);
    check("pp_pre_head", headw(), 32'h200);
    rd = 1'b1;
    step();
    rd = 1'b0;
    check("pp_level", 32'(level), 32'd5);
    check("pp_head", headw(), 32'h201);

    // full frame streamed with slow display reads
    base_addr = 30'h300;
    frame_lo  = 30'h300;
    vga_vsync = 1'b0;
    for (int p = 0; p < 48; p++) begin
      for (int i = 0; i < 19; i++) step();
      if (p == 0) vga_vsync = 1'b1;
      check($sformatf("frm_head%0d", p), headw(), 32'h300 + 32'(p));
      rd = 1'b1;
      step();
      rd = 1'b0;
    end
    step();
    check("frm_unf", 32'(underflow), 32'd0);
    check("frm_level", 32'(level), 32'd0);
    check("frm_acks", 32'(facks), 32'd48);
    check("frm_idle", 32'(mem_req), 32'd0);
    for (int i = 0; i < 30; i++) step();
    check("frm_idle2", 32'(mem_req), 32'd0);
    check("frm_acks2", 32'(facks), 32'd48);

    // reset in the middle of a request
    ack_dly   = 10;
    base_addr = 30'h400;
    vga_vsync = 1'b0;
    for (int i = 0; i < 4; i++) step();
    vga_vsync = 1'b1;
    for (int i = 0; i < 200 && !(level != 0 && mem_req); i++) step();
    check("mr_req", 32'(mem_req), 32'd1);
    check("mr_head", headw(), 32'h400);
    resetn = 1'b0;
    step();
    check("mr_rst_req", 32'(mem_req), 32'd0);
    check("mr_rst_lvl", 32'(level), 32'd0);
    resetn  = 1'b1;
    ack_en  = 0;
    mem_ack = 1'b0;
    step();
    mem_ack  = 1'b1;
    mem_data = 32'hdead_beef;
    step();
    mem_ack = 1'b0;
    step();
    check("late_lvl", 32'(level), 32'd0);
    check("late_req", 32'(mem_req), 32'd0);
    check("late_head", headw(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nasserts, nfail);
    $finish;
  end

endmodule
